// File: rtl/md5_pkg.sv
// MD5 constants, state encoding and per-step helper functions
// shared by the iterative compression engine and its step slice.
package md5_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_e;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Indexed by {round, step mod 4}
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] f_round(
    input logic [1:0]  r,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] f;
    case (r)
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (b & d) | (c & ~d);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    return f;
  endfunction

  // 5i and 3i mod 16 depend only on i mod 16
  function automatic logic [3:0] g_index(input logic [5:0] i);
    logic [3:0] i4;
    logic [3:0] g;
    i4 = i[3:0];
    case (i[5:4])
      2'd0:    g = i4;
      2'd1:    g = i4 * 4'd5 + 4'd1;
      2'd2:    g = i4 * 4'd3 + 4'd5;
      default: g = i4 * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    return S_TAB[{i[5:4], i[1:0]}];
  endfunction

  function automatic logic [31:0] rotl32(
    input logic [31:0] x,
    input logic [4:0]  s
  );
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/md5_compress_iter_step.sv
// One combinational MD5 step: rotates A..D and mixes in
// F, K[i] and M[g] for the step index presented.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0]  a_i,
  input  logic [31:0]  b_i,
  input  logic [31:0]  c_i,
  input  logic [31:0]  d_i,
  input  logic [5:0]   idx_i,
  input  logic [511:0] m_i,
  output logic [31:0]  a_o,
  output logic [31:0]  b_o,
  output logic [31:0]  c_o,
  output logic [31:0]  d_o
);

  logic [31:0] f;
  logic [31:0] mg;
  logic [31:0] sum;
  logic [3:0]  g;

  assign f   = f_round(idx_i[5:4], b_i, c_i, d_i);
  assign g   = g_index(idx_i);
  assign mg  = m_i[{g, 5'd0} +: 32];
  assign sum = a_i + f + K_TAB[idx_i] + mg;

  assign a_o = d_i;
  assign b_o = b_i + rotl32(sum, shift_amt(idx_i));
  assign c_o = b_i;
  assign d_o = c_i;

endmodule

// File: rtl/md5_compress_iter.sv
// Iterative MD5 compression: UNROLL steps per clock over one block,
// then folds the working state into the chaining value.
module md5_compress_iter
  import md5_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int n      = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            first_i,
  input  logic [16*n-1:0] block_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [4*n-1:0]  digest_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 ||
        UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("md5_compress_iter: UNROLL must be 1, 2, 4, 8 or 16");
  end

  if (n != 32) begin : g_bad_n
    $error("md5_compress_iter: n must be 32");
  end

  state_e       state_q;
  logic [6:0]   step_q;
  logic [6:0]   step_d;
  logic [511:0] m_q;
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  ha_q, hb_q, hc_q, hd_q;
  logic [31:0]  ha_d, hb_d, hc_d, hd_d;
  logic [31:0]  a_d, b_d, c_d, d_d;
  logic         ready_q, busy_q, done_q;
  logic [127:0] digest_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_st
    logic [31:0] a_in, b_in, c_in, d_in;
    logic [31:0] a_out, b_out, c_out, d_out;
    logic [5:0]  idx;
    if (k == 0) begin : g_head
      assign a_in = a_q;
      assign b_in = b_q;
      assign c_in = c_q;
      assign d_in = d_q;
    end else begin : g_link
      assign a_in = g_st[k-1].a_out;
      assign b_in = g_st[k-1].b_out;
      assign c_in = g_st[k-1].c_out;
      assign d_in = g_st[k-1].d_out;
    end
    assign idx = step_q[5:0] + 6'(k);
    md5_step u_step (
      .a_i   (a_in),
      .b_i   (b_in),
      .c_i   (c_in),
      .d_i   (d_in),
      .idx_i (idx),
      .m_i   (m_q),
      .a_o   (a_out),
      .b_o   (b_out),
      .c_o   (c_out),
      .d_o   (d_out)
    );
  end

  assign a_d    = g_st[UNROLL-1].a_out;
  assign b_d    = g_st[UNROLL-1].b_out;
  assign c_d    = g_st[UNROLL-1].c_out;
  assign d_d    = g_st[UNROLL-1].d_out;
  assign step_d = step_q + 7'(UNROLL);

  assign ha_d = ha_q + a_q;
  assign hb_d = hb_q + b_q;
  assign hc_d = hc_q + c_q;
  assign hd_d = hd_q + d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      step_q   <= '0;
      m_q      <= '0;
      {a_q, b_q, c_q, d_q}     <= {IV_A, IV_B, IV_C, IV_D};
      {ha_q, hb_q, hc_q, hd_q} <= {IV_A, IV_B, IV_C, IV_D};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            m_q     <= block_i;
            step_q  <= '0;
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (first_i) begin
              {a_q, b_q, c_q, d_q}     <= {IV_A, IV_B, IV_C, IV_D};
              {ha_q, hb_q, hc_q, hd_q} <= {IV_A, IV_B, IV_C, IV_D};
            end else begin
              {a_q, b_q, c_q, d_q} <= {ha_q, hb_q, hc_q, hd_q};
            end
          end
        end
        RUN: begin
          {a_q, b_q, c_q, d_q} <= {a_d, b_d, c_d, d_d};
          step_q <= step_d;
          if (step_d == 7'd64) state_q <= FINAL;
        end
        FINAL: begin
          {ha_q, hb_q, hc_q, hd_q} <= {ha_d, hb_d, hc_d, hd_d};
          digest_q <= {hd_d, hc_d, hb_d, ha_d};
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign digest_o = digest_q;

endmodule
